clock_counter_sched: RTL and testbench
======================================

// Module: clock_counter_sched
// PURPOSE
// Measurement scheduler for the clock-counter datapath. Walks the enabled channels of
// coe_ch_sel round-robin. For each channel it pulses clear, opens a gate window of
// GATE_LEN reference cycles, then waits for the counter result. Results land in a
// per-channel register bank. The bank, control and status are reachable over Avalon-MM (ctrl).
// PARAMETERS
// NR_CH    8    number of measured channels (1..8); ch_sel width = 3
// TMO_CYC  256  max cycles waited for coe_cnt_valid after gate closes
// PORTS
// csi_clk_clk        in   1   single clock; all logic on its rising edge
// rsi_reset_reset    in   1   asynchronous, active-high reset
// avs_ctrl_address   in   9   word address
// avs_ctrl_read      in   1   read strobe
// avs_ctrl_write     in   1   write strobe
// avs_ctrl_readdata  out  32  registered read data, valid 1 cycle after read
// avs_ctrl_writedata in   32  write data
// coe_ch_sel         out  3   channel the counter measures
// coe_clear          out  1   1-cycle counter clear pulse
// coe_gate           out  1   count enable window
// coe_cnt_valid      in   1   1-cycle strobe: coe_cnt_value holds the result
// coe_cnt_value      in   32  count for the channel in coe_ch_sel
// BEHAVIOUR
// Reset: all outputs 0; FSM IDLE; CTRL=0, GATE_LEN=1000, CH_MASK=0xFF; results 0; done=0.
// Register map (word address), R=read-only, R/W=read/write, W1C=write 1 to clear:
// - 0 ID 0xC10C5C4D (R)
// - 1 VERSION 0x00010000 (R)
// - 2 CTRL (R/W): b0 start, write 1 = self-clearing trigger, reads 0; b1 continuous
// - 3 STATUS: b0 busy (R); b1 done (sticky, W1C); b2 timeout (sticky, W1C); [10:8] cur ch (R)
// - 4 GATE_LEN (R/W): 32 bit, cycles
// - 5 CH_MASK (R/W): [NR_CH-1:0]
// - 16+n RESULT[n] (R) for n < NR_CH
// - Any other address reads 0xDEADBEEF; writes to it are ignored.
// FSM: IDLE -> CLEAR -> GATE -> WAIT -> STORE -> (CLEAR of next channel | IDLE)
// - IDLE: start=1 with mask!=0 -> latch GATE_LEN and mask; ch=lowest set bit -> CLEAR.
//   start=1 with mask==0: set done, stay IDLE, busy stays 0.
// - CLEAR: coe_clear=1 for exactly 1 cycle; coe_ch_sel=ch -> GATE.
// - GATE: coe_gate=1 for exactly max(GATE_LEN,1) cycles; GATE_LEN=0 behaves as 1 -> WAIT.
// - WAIT: on coe_cnt_valid capture coe_cnt_value -> STORE. If no valid after TMO_CYC
//   cycles: result=0xFFFFFFFF, set timeout -> STORE.
// - STORE: write RESULT[ch]; advance to next set mask bit above ch.
//   - Next bit found: -> CLEAR.
//   - None above ch: sweep done, set done. Continuous=1 -> wrap to lowest bit, relatch
//     GATE_LEN and mask, -> CLEAR. Else -> IDLE.
// coe_ch_sel is stable from CLEAR through STORE. busy=1 in every state except IDLE.
// coe_cnt_valid outside WAIT is ignored.
// Writes to GATE_LEN/CH_MASK while busy do not touch the current sweep; they apply at the next latch.
// Continuous cleared mid-sweep: the current sweep completes, then -> IDLE.
// start written while busy is ignored.
// Read and write on the same cycle and address: read returns the pre-write value.
// W1C and a done/timeout set on the same cycle: the set wins.
// Async reset mid-sweep: immediate return to reset values; gate/clear drop at once.
// TESTING
// - Reset, then read addr 0,1,3,6 -> 0xC10C5C4D, 0x00010000, 0x0, 0xDEADBEEF (1-cycle latency).
// - mask=0x05, GATE_LEN=10, start; model replies valid with 100+ch 3 cycles after gate falls.
//   Expect ch 0 then ch 2, gate high 10 cycles each; RESULT[0]=100, RESULT[2]=102; done=1, busy=0.
// - mask=0x01; model never asserts valid -> RESULT[0]=0xFFFFFFFF, timeout=1 after
//   TMO_CYC cycles. Write 0x6 to STATUS -> done and timeout read 0.
// - continuous=1, mask=0x81. Change GATE_LEN to 5 during ch 7, then clear continuous.
//   Expect the next sweep uses 5-cycle gates; FSM ends in IDLE after that sweep.
// - start with mask=0 -> done=1, coe_clear/coe_gate never asserted.
// - Assert reset during GATE -> coe_gate=0 the same cycle, STATUS=0, FSM IDLE.

Source files
------------

// File: rtl/clock_counter_sched.sv
// clock_counter_sched
// Sweeps the enabled channels in ascending order. For each channel it clears the
// external counter, opens a count window, waits for the result and stores it in a
// per-channel bank. Control, status and results are read over Avalon-MM.
module clock_counter_sched #(
    parameter int NR_CH   = 8,
    parameter int TMO_CYC = 256
) (
    input  logic        csi_clk_clk,
    input  logic        rsi_reset_reset,
    input  logic [8:0]  avs_ctrl_address,
    input  logic        avs_ctrl_read,
    input  logic        avs_ctrl_write,
    output logic [31:0] avs_ctrl_readdata,
    input  logic [31:0] avs_ctrl_writedata,
    output logic [2:0]  coe_ch_sel,
    output logic        coe_clear,
    output logic        coe_gate,
    input  logic        coe_cnt_valid,
    input  logic [31:0] coe_cnt_value
);

    localparam logic [31:0] ID_VAL  = 32'hC10C5C4D;
    localparam logic [31:0] VER_VAL = 32'h00010000;
    localparam logic [31:0] BAD_VAL = 32'hDEADBEEF;
    localparam int          TMO_W   = $clog2(TMO_CYC + 1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CLEAR = 3'd1;
    localparam logic [2:0] ST_GATE  = 3'd2;
    localparam logic [2:0] ST_WAIT  = 3'd3;
    localparam logic [2:0] ST_STORE = 3'd4;

    logic             clk;
    logic             rst;
    assign clk = csi_clk_clk;
    assign rst = rsi_reset_reset;

    logic [2:0]       state_reg;
    logic [2:0]       ch_reg;
    logic             cont_reg;
    logic [31:0]      gate_len_reg;
    logic [NR_CH-1:0] ch_mask_reg;
    logic [31:0]      lat_gate_reg;
    logic [NR_CH-1:0] lat_mask_reg;
    logic [31:0]      gate_cnt_reg;
    logic [TMO_W-1:0] tmo_cnt_reg;
    logic [31:0]      cap_reg;
    logic             done_reg;
    logic             timeout_reg;
    logic [31:0]      readdata_reg;
    logic [31:0]      result_reg [NR_CH];

    logic             busy;
    logic             wr_ctrl, wr_status, wr_gate, wr_mask;
    logic             start_req;
    logic             done_set, timeout_set;
    logic             next_found;
    logic [2:0]       next_ch;
    logic [2:0]       first_ch;
    logic [8:0]       res_off;
    logic [31:0]      rd_mux;

    assign busy      = (state_reg != ST_IDLE);
    assign wr_ctrl   = avs_ctrl_write && (avs_ctrl_address == 9'd2);
    assign wr_status = avs_ctrl_write && (avs_ctrl_address == 9'd3);
    assign wr_gate   = avs_ctrl_write && (avs_ctrl_address == 9'd4);
    assign wr_mask   = avs_ctrl_write && (avs_ctrl_address == 9'd5);
    // A start written while a sweep is running is dropped.
    assign start_req = wr_ctrl && avs_ctrl_writedata[0] && !busy;

    assign done_set    = (start_req && (ch_mask_reg == '0)) ||
                         ((state_reg == ST_STORE) && !next_found);
    assign timeout_set = (state_reg == ST_WAIT) && !coe_cnt_valid &&
                         (tmo_cnt_reg == TMO_W'(TMO_CYC - 1));

    // Clear and gate decode straight from state so an async reset drops them at once.
    assign coe_clear         = (state_reg == ST_CLEAR);
    assign coe_gate          = (state_reg == ST_GATE);
    assign coe_ch_sel        = ch_reg;
    assign avs_ctrl_readdata = readdata_reg;

    // Next enabled channel above the current one within the latched mask.
    always_comb begin
        next_found = 1'b0;
        next_ch    = ch_reg;
        for (int i = NR_CH - 1; i >= 0; i--) begin
            if (lat_mask_reg[i] && (3'(i) > ch_reg)) begin
                next_found = 1'b1;
                next_ch    = 3'(i);
            end
        end
    end

    // Lowest enabled channel of the live mask, used when a sweep (re)starts.
    always_comb begin
        first_ch = 3'd0;
        for (int i = NR_CH - 1; i >= 0; i--) begin
            if (ch_mask_reg[i]) begin
                first_ch = 3'(i);
            end
        end
    end

    // Measurement sequencer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            ch_reg       <= 3'd0;
            lat_gate_reg <= 32'd0;
            lat_mask_reg <= '0;
            gate_cnt_reg <= 32'd0;
            tmo_cnt_reg  <= '0;
            cap_reg      <= 32'd0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start_req && (ch_mask_reg != '0)) begin
                        lat_gate_reg <= gate_len_reg;
                        lat_mask_reg <= ch_mask_reg;
                        ch_reg       <= first_ch;
                        state_reg    <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    // A zero length still opens the window for one cycle.
                    gate_cnt_reg <= (lat_gate_reg == 32'd0) ? 32'd0 : lat_gate_reg - 32'd1;
                    state_reg    <= ST_GATE;
                end
                ST_GATE: begin
                    if (gate_cnt_reg == 32'd0) begin
                        tmo_cnt_reg <= '0;
                        state_reg   <= ST_WAIT;
                    end else begin
                        gate_cnt_reg <= gate_cnt_reg - 32'd1;
                    end
                end
                ST_WAIT: begin
                    if (coe_cnt_valid) begin
                        cap_reg   <= coe_cnt_value;
                        state_reg <= ST_STORE;
                    end else if (tmo_cnt_reg == TMO_W'(TMO_CYC - 1)) begin
                        cap_reg   <= 32'hFFFFFFFF;
                        state_reg <= ST_STORE;
                    end else begin
                        tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
                    end
                end
                ST_STORE: begin
                    if (next_found) begin
                        ch_reg    <= next_ch;
                        state_reg <= ST_CLEAR;
                    end else if (cont_reg && (ch_mask_reg != '0)) begin
                        lat_gate_reg <= gate_len_reg;
                        lat_mask_reg <= ch_mask_reg;
                        ch_reg       <= first_ch;
                        state_reg    <= ST_CLEAR;
                    end else begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // Result bank: one register per channel, written in STORE.
    generate
        for (genvar gi = 0; gi < NR_CH; gi++) begin : g_result
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    result_reg[gi] <= 32'd0;
                end else if ((state_reg == ST_STORE) && (ch_reg == 3'(gi))) begin
                    result_reg[gi] <= cap_reg;
                end
            end
        end
    endgenerate

    // Control registers and sticky flags; a same-cycle set beats the W1C.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cont_reg     <= 1'b0;
            gate_len_reg <= 32'd1000;
            ch_mask_reg  <= '1;
            done_reg     <= 1'b0;
            timeout_reg  <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                cont_reg <= avs_ctrl_writedata[1];
            end
            if (wr_gate) begin
                gate_len_reg <= avs_ctrl_writedata;
            end
            if (wr_mask) begin
                ch_mask_reg <= avs_ctrl_writedata[NR_CH-1:0];
            end
            if (done_set) begin
                done_reg <= 1'b1;
            end else if (wr_status && avs_ctrl_writedata[1]) begin
                done_reg <= 1'b0;
            end
            if (timeout_set) begin
                timeout_reg <= 1'b1;
            end else if (wr_status && avs_ctrl_writedata[2]) begin
                timeout_reg <= 1'b0;
            end
        end
    end

    assign res_off = avs_ctrl_address - 9'd16;

    // Read mux over the pre-write register values.
    always_comb begin
        rd_mux = BAD_VAL;
        case (avs_ctrl_address)
            9'd0: rd_mux = ID_VAL;
            9'd1: rd_mux = VER_VAL;
            9'd2: rd_mux = {30'd0, cont_reg, 1'b0};
            9'd3: rd_mux = {21'd0, ch_reg, 5'd0, timeout_reg, done_reg, busy};
            9'd4: rd_mux = gate_len_reg;
            9'd5: rd_mux = 32'(ch_mask_reg);
            default: begin
                if ((avs_ctrl_address >= 9'd16) && (res_off < 9'(NR_CH))) begin
                    rd_mux = result_reg[res_off[2:0]];
                end
            end
        endcase
    end

    // Registered read data, one cycle after the strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            readdata_reg <= 32'd0;
        end else if (avs_ctrl_read) begin
            readdata_reg <= rd_mux;
        end
    end

endmodule

// File: tb/tb_clock_counter_sched.sv
// Bench for clock_counter_sched: register map, sweeps, timeout, continuous mode, reset.
module tb_clock_counter_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [8:0]  address = '0;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic [31:0] readdata;
    logic [31:0] writedata = '0;
    logic [2:0]  ch_sel;
    logic        clr;
    logic        gate;
    logic        cnt_valid = 1'b0;
    logic [31:0] cnt_value = '0;

    int n_checks = 0;
    int n_fail   = 0;

    clock_counter_sched #(.NR_CH(8), .TMO_CYC(256)) dut (
        .csi_clk_clk        (clk),
        .rsi_reset_reset    (rst),
        .avs_ctrl_address   (address),
        .avs_ctrl_read      (rd),
        .avs_ctrl_write     (wr),
        .avs_ctrl_readdata  (readdata),
        .avs_ctrl_writedata (writedata),
        .coe_ch_sel         (ch_sel),
        .coe_clear          (clr),
        .coe_gate           (gate),
        .coe_cnt_valid      (cnt_valid),
        .coe_cnt_value      (cnt_value)
    );

    always #5 clk = ~clk;

    // Counter model: records each gate window and answers 3 cycles after it closes.
    typedef struct { logic [2:0] ch; int len; } gate_rec_t;
    gate_rec_t hist[$];
    bit model_en  = 1'b1;
    bit gate_prev = 1'b0;
    int gate_run  = 0;
    int dly       = 0;
    int clear_cnt = 0;
    int gate_cnt  = 0;

    always @(negedge clk) begin
        cnt_valid = 1'b0;
        if (clr) clear_cnt++;
        if (gate) begin
            gate_run++;
            gate_cnt++;
        end else if (gate_prev) begin
            hist.push_back('{ch_sel, gate_run});
            gate_run = 0;
            dly = model_en ? 3 : 0;
        end else if (dly > 0) begin
            dly--;
            if (dly == 0) begin
                cnt_valid = 1'b1;
                cnt_value = 32'd100 + 32'(ch_sel);
            end
        end
        gate_prev = gate;
    end

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%08h", name, act);
        end
    endfunction

    task automatic bus_write(input logic [8:0] a, input logic [31:0] d);
        @(negedge clk);
        address = a; writedata = d; wr = 1'b1;
        @(negedge clk);
        wr = 1'b0;
    endtask

    task automatic bus_read(input logic [8:0] a, output logic [31:0] d);
        @(negedge clk);
        address = a; rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        d = readdata;
    endtask

    task automatic wait_idle(input string name);
        logic [31:0] s;
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            bus_read(9'd3, s);
            if (s[0] == 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        check(name, 32'(ok), 32'd1);
    endtask

    task automatic wait_gate_ch(input logic [2:0] ch, input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (gate && ch_sel == ch) begin
                ok = 1'b1;
                break;
            end
        end
        check(name, 32'(ok), 32'd1);
    endtask

    typedef struct { logic [8:0] addr; logic [31:0] exp; } rd_vec_t;
    rd_vec_t vecs[11];

    logic [31:0] d;
    bit ok;

    initial begin
        vecs[0]  = '{9'd0,   32'hC10C5C4D};
        vecs[1]  = '{9'd1,   32'h00010000};
        vecs[2]  = '{9'd3,   32'h00000000};
        vecs[3]  = '{9'd6,   32'hDEADBEEF};
        vecs[4]  = '{9'd2,   32'h00000000};
        vecs[5]  = '{9'd4,   32'd1000};
        vecs[6]  = '{9'd5,   32'h000000FF};
        vecs[7]  = '{9'd16,  32'h00000000};
        vecs[8]  = '{9'd23,  32'h00000000};
        vecs[9]  = '{9'd24,  32'hDEADBEEF};
        vecs[10] = '{9'd511, 32'hDEADBEEF};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_gate", 32'(gate), 32'd0);
        check("rst_clear", 32'(clr), 32'd0);
        rst = 1'b0;
        check("rst_chsel", 32'(ch_sel), 32'd0);
        for (int i = 0; i < 11; i++) begin
            bus_read(vecs[i].addr, d);
            check($sformatf("reset_read_a%0d", vecs[i].addr), d, vecs[i].exp);
        end

        // Two-channel sweep, 10-cycle gates
        bus_write(9'd5, 32'h05);
        bus_write(9'd4, 32'd10);
        hist.delete();
        bus_write(9'd2, 32'h1);
        wait_idle("sweep_idle");
        check("sweep_ngates", 32'(hist.size()), 32'd2);
        if (hist.size() == 2) begin
            check("sweep_g0_ch", 32'(hist[0].ch), 32'd0);
            check("sweep_g0_len", 32'(hist[0].len), 32'd10);
            check("sweep_g1_ch", 32'(hist[1].ch), 32'd2);
            check("sweep_g1_len", 32'(hist[1].len), 32'd10);
        end
        bus_read(9'd16, d); check("result0", d, 32'd100);
        bus_read(9'd17, d); check("result1_untouched", d, 32'd0);
        bus_read(9'd18, d); check("result2", d, 32'd102);
        bus_read(9'd3, d);  check("sweep_status", d & 32'h7, 32'h2);

        // Timeout on channel 0
        bus_write(9'd3, 32'h6);
        bus_read(9'd3, d); check("w1c_done", d & 32'h7, 32'h0);
        model_en = 1'b0;
        bus_write(9'd5, 32'h01);
        hist.delete();
        bus_write(9'd2, 32'h1);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (hist.size() > 0) begin ok = 1'b1; break; end
        end
        check("tmo_gate_seen", 32'(ok), 32'd1);
        repeat (250) @(negedge clk);
        bus_read(9'd3, d); check("tmo_still_waiting", d & 32'h7, 32'h1);
        wait_idle("tmo_idle");
        bus_read(9'd3, d);  check("tmo_status", d & 32'h7, 32'h6);
        bus_read(9'd16, d); check("tmo_result0", d, 32'hFFFFFFFF);
        bus_write(9'd3, 32'h6);
        bus_read(9'd3, d);  check("tmo_w1c", d & 32'h7, 32'h0);
        model_en = 1'b1;

        // GATE_LEN = 0 behaves as a 1-cycle gate
        bus_write(9'd5, 32'h02);
        bus_write(9'd4, 32'd0);
        hist.delete();
        bus_write(9'd2, 32'h1);
        wait_idle("g0_idle");
        check("g0_ngates", 32'(hist.size()), 32'd1);
        if (hist.size() == 1) check("g0_len", 32'(hist[0].len), 32'd1);
        bus_read(9'd17, d); check("g0_result1", d, 32'd101);

        // Continuous sweep, gate length change and stop
        bus_write(9'd5, 32'h81);
        bus_write(9'd4, 32'd10);
        hist.delete();
        bus_write(9'd2, 32'h3);
        wait_gate_ch(3'd7, "cont_ch7_seen");
        bus_write(9'd4, 32'd5);
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (clr && ch_sel == 3'd0) begin ok = 1'b1; break; end
        end
        check("cont_sweep2_seen", 32'(ok), 32'd1);
        bus_write(9'd2, 32'h0);
        wait_idle("cont_idle");
        check("cont_ngates", 32'(hist.size()), 32'd4);
        if (hist.size() == 4) begin
            check("cont_g0_len", 32'(hist[0].len), 32'd10);
            check("cont_g1", {hist[1].ch, 29'(hist[1].len)}, {3'd7, 29'd10});
            check("cont_g2", {hist[2].ch, 29'(hist[2].len)}, {3'd0, 29'd5});
            check("cont_g3", {hist[3].ch, 29'(hist[3].len)}, {3'd7, 29'd5});
        end
        bus_read(9'd23, d); check("cont_result7", d, 32'd107);

        // Start with an empty mask
        bus_write(9'd3, 32'h6);
        bus_write(9'd5, 32'h0);
        clear_cnt = 0;
        gate_cnt  = 0;
        bus_write(9'd2, 32'h1);
        repeat (20) @(negedge clk);
        bus_read(9'd3, d); check("mask0_status", d & 32'h7, 32'h2);
        check("mask0_clears", 32'(clear_cnt), 32'd0);
        check("mask0_gates", 32'(gate_cnt), 32'd0);

        // Async reset during the gate window
        bus_write(9'd5, 32'h01);
        bus_write(9'd4, 32'd10);
        bus_write(9'd2, 32'h1);
        wait_gate_ch(3'd0, "rst_gate_seen");
        #2 rst = 1'b1;
        #1;
        check("rst_async_gate", 32'(gate), 32'd0);
        check("rst_async_clear", 32'(clr), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bus_read(9'd3, d);  check("rst_status", d, 32'h0);
        bus_read(9'd4, d);  check("rst_gatelen", d, 32'd1000);
        bus_read(9'd5, d);  check("rst_mask", d, 32'hFF);
        bus_read(9'd16, d); check("rst_result0", d, 32'h0);
        repeat (20) @(negedge clk);
        check("rst_stays_idle", 32'(gate), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
